// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the ID/EX pipeline register's datapath and control signals.
//   in_*      : decoded instruction and register-file read data from ID
//   ex_wdata  : result currently produced by EX (forwarding source)
//   wb_*      : write-back port of the register file (forwarding source)
//   hold      : downstream stall, freezes the stage
//   flush     : branch mispredict, kills the instruction held in ID/EX
//   out_*     : registered EX-stage instruction
//   stall_up  : combinational request for fetch/decode to hold their state
// Modports: slave = the pipeline stage, master = the surrounding pipeline.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int n   = 8,
  parameter int OPW = 4
) ();
  logic           in_valid;
  logic [3:0]     in_raddr1;
  logic [3:0]     in_raddr2;
  logic [n-1:0]   in_rdata1;
  logic [n-1:0]   in_rdata2;
  logic [n-1:0]   in_imm;
  logic [OPW-1:0] in_op;
  logic           in_wen;
  logic           in_is_load;
  logic           in_pred_taken;
  logic [n-1:0]   ex_wdata;
  logic           wb_wen;
  logic [3:0]     wb_waddr;
  logic [n-1:0]   wb_wdata;
  logic           hold;
  logic           flush;
  logic           out_valid;
  logic [n-1:0]   out_a;
  logic [n-1:0]   out_b;
  logic [n-1:0]   out_imm;
  logic [OPW-1:0] out_op;
  logic [3:0]     out_dest;
  logic           out_wen;
  logic           out_is_load;
  logic           out_pred_taken;
  logic           stall_up;

  modport slave (
    input  in_valid, in_raddr1, in_raddr2, in_rdata1, in_rdata2, in_imm,
           in_op, in_wen, in_is_load, in_pred_taken, ex_wdata, wb_wen,
           wb_waddr, wb_wdata, hold, flush,
    output out_valid, out_a, out_b, out_imm, out_op, out_dest, out_wen,
           out_is_load, out_pred_taken, stall_up
  );

  modport master (
    output in_valid, in_raddr1, in_raddr2, in_rdata1, in_rdata2, in_imm,
           in_op, in_wen, in_is_load, in_pred_taken, ex_wdata, wb_wen,
           wb_waddr, wb_wdata, hold, flush,
    input  out_valid, out_a, out_b, out_imm, out_op, out_dest, out_wen,
           out_is_load, out_pred_taken, stall_up
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the picoMIPS pipeline. Captures the decoded
// instruction and its two operands each cycle, forwarding from EX and WB
// because the register file writes on the clock edge but reads
// combinationally. Detects load-use hazards (one bubble), honours downstream
// hold and injects a bubble on a branch-mispredict flush.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : id_ex_stage_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int n   = 8,
  parameter int OPW = 4
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic           valid;
    logic [n-1:0]   a;
    logic [n-1:0]   b;
    logic [n-1:0]   imm;
    logic [OPW-1:0] op;
    logic [3:0]     dest;
    logic           wen;
    logic           is_load;
    logic           pred_taken;
  } ex_reg_t;

  ex_reg_t      ex_q;
  logic         ex_src_ok;
  logic         wb_src_ok;
  logic         ex_hit1;
  logic         ex_hit2;
  logic         wb_hit1;
  logic         wb_hit2;
  logic [n-1:0] op_a;
  logic [n-1:0] op_b;
  logic         load_use;

  // Forwarding and hazard detection, all derived from the instruction
  // currently in EX (this stage's own registers) and the WB write port.
  // NOTE: every signal gets a value on every path through this block, so no
  // latch is inferred.
  always_comb begin
    // A load's result is not ready in EX, so it is never an EX forward source;
    // register 0 is hard-wired zero and never forwarded.
    ex_src_ok = ex_q.valid & ex_q.wen & ~ex_q.is_load & (ex_q.dest != 4'd0);
    wb_src_ok = bus.wb_wen & (bus.wb_waddr != 4'd0);

    ex_hit1 = ex_src_ok & (ex_q.dest == bus.in_raddr1);
    ex_hit2 = ex_src_ok & (ex_q.dest == bus.in_raddr2);
    wb_hit1 = wb_src_ok & (bus.wb_waddr == bus.in_raddr1);
    wb_hit2 = wb_src_ok & (bus.wb_waddr == bus.in_raddr2);

    // EX holds the youngest value, so it beats WB.
    op_a = ex_hit1 ? bus.ex_wdata : (wb_hit1 ? bus.wb_wdata : bus.in_rdata1);
    op_b = ex_hit2 ? bus.ex_wdata : (wb_hit2 ? bus.wb_wdata : bus.in_rdata2);

    load_use = bus.in_valid & ex_q.valid & ex_q.is_load & ex_q.wen &
               (ex_q.dest != 4'd0) &
               ((ex_q.dest == bus.in_raddr1) | (ex_q.dest == bus.in_raddr2));
  end

  // A flush kills the stalling instruction's successor anyway, so it
  // releases the upstream stall.
  assign bus.stall_up = ~reset & ~bus.flush & (bus.hold | load_use);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this is a handful of flops, not a memory, so clearing all of
      // them on reset is cheap and gives a fully defined EX stage.
      ex_q <= '0;
    end else if (bus.flush) begin
      // Only the control bits matter for a killed instruction; the datapath
      // fields simply keep their value.
      ex_q.valid   <= 1'b0;
      ex_q.wen     <= 1'b0;
      ex_q.is_load <= 1'b0;
    end else if (bus.hold) begin
      ex_q <= ex_q;
    end else if (load_use) begin
      // Bubble; the dependent instruction stays in ID via stall_up and picks
      // the load data up from WB next cycle.
      ex_q.valid   <= 1'b0;
      ex_q.wen     <= 1'b0;
      ex_q.is_load <= 1'b0;
    end else begin
      ex_q.valid      <= bus.in_valid;
      ex_q.a          <= op_a;
      ex_q.b          <= op_b;
      ex_q.imm        <= bus.in_imm;
      ex_q.op         <= bus.in_op;
      ex_q.dest       <= bus.in_raddr2;
      ex_q.wen        <= bus.in_wen & bus.in_valid;
      ex_q.is_load    <= bus.in_is_load & bus.in_valid;
      ex_q.pred_taken <= bus.in_pred_taken;
    end
  end

  assign bus.out_valid      = ex_q.valid;
  assign bus.out_a          = ex_q.a;
  assign bus.out_b          = ex_q.b;
  assign bus.out_imm        = ex_q.imm;
  assign bus.out_op         = ex_q.op;
  assign bus.out_dest       = ex_q.dest;
  assign bus.out_wen        = ex_q.wen;
  assign bus.out_is_load    = ex_q.is_load;
  assign bus.out_pred_taken = ex_q.pred_taken;

endmodule
